// File: rtl/gate_controller.sv
// Purpose : barrier-gate actuator answering the parking FSM's one-cycle open request.
// Latency : every output is decoded from registered state, so an input acts one cycle after it is sampled.
// Backpressure: none; open_req is a fire-and-forget pulse, and busy tells the requester a cycle is in progress.
module gate_controller #(
  parameter int MOVE_TIMEOUT = 80000000,  // cycles allowed in OPENING or CLOSING
  parameter int HOLD_CYC     = 120000000, // car-free cycles before auto-close
  parameter int CNT_W        = 28         // timer width, must hold both limits
) (
  input  logic clk,
  input  logic reset_n,
  input  logic open_req,
  input  logic car_present,
  input  logic lim_up,
  input  logic lim_down,
  output logic motor_up,
  output logic motor_down,
  output logic gate_open,
  output logic busy,
  output logic done,
  output logic fault
);

  // State encoding is kept as plain constants for compatibility with older tooling.
  localparam logic [2:0] ST_CLOSED    = 3'd0;
  localparam logic [2:0] ST_OPENING   = 3'd1;
  localparam logic [2:0] ST_OPEN_HOLD = 3'd2;
  localparam logic [2:0] ST_CLOSING   = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  // Terminal timer values. A state expires on the cycle its timer shows the last value.
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMR_MAX   = '1;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] tmr_q;
  logic [CNT_W-1:0] tmr_d;
  logic [CNT_W-1:0] tmr_inc;
  logic             done_q;

  // Named conditions, so the next-state logic reads like the gate's rules.
  logic sensor_conflict;  // both limit switches claim to be made: wiring or switch failure
  logic reversal;         // something is under, or wants through, a closing gate
  logic hold_restart;     // a car or a fresh request keeps the gate up longer
  logic move_expired;     // the motor has run too long without reaching a limit
  logic hold_expired;     // the gate has been up and clear long enough

  assign sensor_conflict = lim_up & lim_down;
  assign reversal        = car_present | open_req;
  assign hold_restart    = car_present | open_req;
  assign move_expired    = (tmr_q == MOVE_LAST);
  assign hold_expired    = (tmr_q == HOLD_LAST) & ~hold_restart;

  // The timer stops at all-ones rather than wrapping back to a small value.
  assign tmr_inc = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + CNT_W'(1);

  // Next-state selection; a sensor conflict overrides everything, including the current state.
  always_comb begin
    state_d = state_q;
    if (sensor_conflict) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_CLOSED: begin
          // A request wins over self-homing; otherwise a gate that is not
          // down (after reset or drift) is driven back down.
          if (open_req) begin
            state_d = ST_OPENING;
          end else if (!lim_down) begin
            state_d = ST_CLOSING;
          end
        end
        ST_OPENING: begin
          // Further requests are irrelevant: the gate is already on its way up.
          if (lim_up) begin
            state_d = ST_OPEN_HOLD;
          end else if (move_expired) begin
            state_d = ST_FAULT;
          end
        end
        ST_OPEN_HOLD: begin
          // lim_up dropping here is deliberately ignored; only the hold timer ends the hold.
          if (hold_expired) begin
            state_d = ST_CLOSING;
          end
        end
        ST_CLOSING: begin
          // Reversal outranks lim_down so a car arriving at the last moment is never trapped.
          if (reversal) begin
            state_d = ST_OPENING;
          end else if (lim_down) begin
            state_d = ST_CLOSED;
          end else if (move_expired) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          // Sticky: only reset_n leaves this state.
          state_d = ST_FAULT;
        end
        default: begin
          // An unreachable encoding is treated as a fault, which keeps the motors off.
          state_d = ST_FAULT;
        end
      endcase
    end
  end

  // Timer update: cleared on every state change, otherwise it counts the time spent in the current state.
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      tmr_d = '0;
    end else begin
      case (state_q)
        ST_OPENING,
        ST_CLOSING:   tmr_d = tmr_inc;
        ST_OPEN_HOLD: tmr_d = hold_restart ? '0 : tmr_inc;
        default:      tmr_d = '0;
      endcase
    end
  end

  // State and timer registers; asynchronous reset drops the motors immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLOSED;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // done marks the first CLOSED cycle after a close that reached lim_down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_CLOSING) && (state_d == ST_CLOSED);
    end
  end

  // Moore decode. Each motor output depends on a single state value, so both can never be on together.
  assign motor_up   = (state_q == ST_OPENING);
  assign motor_down = (state_q == ST_CLOSING);
  assign gate_open  = (state_q == ST_OPEN_HOLD);
  assign busy       = (state_q != ST_CLOSED);
  assign fault      = (state_q == ST_FAULT);
  assign done       = done_q;

endmodule

// File: tb/tb_gate_controller.sv
// Purpose : directed and random checks of gate_controller against a phase-level model.
// Latency : inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Backpressure: not applicable.
module tb_gate_controller;

  localparam int MT = 16;
  localparam int HC = 8;
  localparam int CW = 28;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic open_req = 1'b0;
  logic car_present = 1'b0;
  logic lim_up = 1'b0;
  logic lim_down = 1'b1;
  logic motor_up, motor_down, gate_open, busy, done, fault;

  gate_controller #(.MOVE_TIMEOUT(MT), .HOLD_CYC(HC), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .open_req(open_req), .car_present(car_present),
    .lim_up(lim_up), .lim_down(lim_down), .motor_up(motor_up), .motor_down(motor_down),
    .gate_open(gate_open), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Reference model: which phase the gate is in and how long it has been there.
  typedef enum int {P_CLOSED, P_OPENING, P_HOLD, P_CLOSING, P_FAULT} phase_t;
  phase_t ph = P_CLOSED;
  int     elapsed = 0;
  logic   m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".motor_up"},   motor_up,   ph == P_OPENING);
    chk({tag, ".motor_down"}, motor_down, ph == P_CLOSING);
    chk({tag, ".gate_open"},  gate_open,  ph == P_HOLD);
    chk({tag, ".busy"},       busy,       ph != P_CLOSED);
    chk({tag, ".fault"},      fault,      ph == P_FAULT);
    chk({tag, ".done"},       done,       m_done);
    chk({tag, ".interlock"},  motor_up & motor_down, 1'b0);
  endtask

  // Advance the model by one clock using the inputs presently applied.
  task automatic model_edge();
    phase_t nx;
    nx = ph;
    if (lim_up && lim_down) nx = P_FAULT;
    else begin
      case (ph)
        P_CLOSED:  if (open_req) nx = P_OPENING; else if (!lim_down) nx = P_CLOSING;
        P_OPENING: if (lim_up) nx = P_HOLD; else if (elapsed + 1 >= MT) nx = P_FAULT;
        P_HOLD:    if (!car_present && !open_req && elapsed + 1 >= HC) nx = P_CLOSING;
        P_CLOSING: if (car_present || open_req) nx = P_OPENING;
                   else if (lim_down) nx = P_CLOSED;
                   else if (elapsed + 1 >= MT) nx = P_FAULT;
        default:   nx = P_FAULT;
      endcase
    end
    m_done = (ph == P_CLOSING) && (nx == P_CLOSED);
    if (nx != ph) elapsed = 0;
    else if (ph == P_HOLD) elapsed = (car_present || open_req) ? 0 : elapsed + 1;
    else if (ph == P_OPENING || ph == P_CLOSING) elapsed = elapsed + 1;
    ph = nx;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk_model("cyc");
    if (done) done_cnt++;
  endtask

  // Assert reset asynchronously, check outputs drop at once, then release with the given lim_down.
  task automatic do_reset(input logic ld);
    reset_n = 1'b0;
    #1;
    ph = P_CLOSED;
    elapsed = 0;
    m_done = 1'b0;
    chk_model("reset");
    @(posedge clk);
    #1;
    open_req = 1'b0;
    car_present = 1'b0;
    lim_up = 1'b0;
    lim_down = ld;
    reset_n = 1'b1;
  endtask

  int n;
  int r;

  initial begin
    // Normal open/hold/close cycle.
    do_reset(1'b1);
    done_cnt = 0;
    open_req = 1'b1; step();                      // cycle 1
    open_req = 1'b0; lim_down = 1'b0;
    chk("norm_up_c1", motor_up, 1'b1);
    repeat (4) step();                            // cycle 5
    chk("norm_no_open_c5", gate_open, 1'b0);
    lim_up = 1'b1; step();                        // cycle 6
    chk("norm_open_c6", gate_open, 1'b1);
    repeat (7) step();                            // cycle 13
    chk("norm_open_c13", gate_open, 1'b1);
    step();                                       // cycle 14
    chk("norm_closing_c14", motor_down, 1'b1);
    lim_up = 1'b0;
    step(); step();                               // cycle 16
    lim_down = 1'b1; step();                      // cycle 17
    chk("norm_done", done, 1'b1);
    step();
    chk("norm_busy_after", busy, 1'b0);
    chk("norm_done_once", done_cnt, 1);

    // Hold extension by a car under the barrier.
    open_req = 1'b1; step();
    open_req = 1'b0; lim_down = 1'b0;
    repeat (2) step();
    lim_up = 1'b1; step();                        // hold cycle 0
    chk("hold_entered", gate_open, 1'b1);
    repeat (3) step();                            // hold cycle 3
    car_present = 1'b1;
    repeat (8) step();                            // hold cycle 11
    car_present = 1'b0;
    n = 0;
    while (!motor_down && n < 20) begin
      step();
      n++;
    end
    chk("hold_ext_cycles", n, 8);

    // Safety reversal beats lim_down in the same cycle.
    lim_up = 1'b0;
    done_cnt = 0;
    car_present = 1'b1; lim_down = 1'b1; step();
    chk("rev_up", motor_up, 1'b1);
    chk("rev_down", motor_down, 1'b0);
    chk("rev_no_done", done, 1'b0);
    car_present = 1'b0; lim_down = 1'b0;
    step();
    // Reset in mid-motion: motors must drop without waiting for a clock.
    chk("mid_motion_up", motor_up, 1'b1);
    do_reset(1'b1);

    // Move timeout with lim_up never arriving.
    open_req = 1'b1; step();
    open_req = 1'b0; lim_down = 1'b0;
    repeat (15) step();                           // cycle 16
    chk("to_no_fault_c16", fault, 1'b0);
    step();                                       // cycle 17
    chk("to_fault_c17", fault, 1'b1);
    chk("to_motor_up", motor_up, 1'b0);
    chk("to_motor_down", motor_down, 1'b0);
    open_req = 1'b1; step();
    open_req = 1'b0; step();
    chk("to_req_ignored", fault, 1'b1);
    do_reset(1'b1);
    chk("to_reset_clears", fault, 1'b0);

    // Limit conflict in OPEN_HOLD.
    open_req = 1'b1; step();
    open_req = 1'b0; lim_down = 1'b0;
    lim_up = 1'b1; step();
    chk("conf_hold", gate_open, 1'b1);
    lim_down = 1'b1; step();
    chk("conf_fault", fault, 1'b1);

    // Self-homing after reset with the gate not down.
    do_reset(1'b0);
    chk("home_idle", motor_down, 1'b0);
    step();
    chk("home_down", motor_down, 1'b1);

    // Random traffic, every cycle checked against the model.
    do_reset(1'b1);
    for (int i = 0; i < 10000; i++) begin
      open_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) car_present = ~car_present;
      r = $urandom_range(0, 299);
      lim_up   = (r == 0) || (r >= 1 && r < 40);
      lim_down = (r == 0) || (r >= 40 && r < 80);
      step();
      if (ph == P_FAULT && $urandom_range(0, 3) == 0) do_reset(lim_down);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_controller.md
Name: gate_controller

Overview:
- Barrier-gate actuator that services the single-cycle door-open request issued by the parking FSM, responding to it as the other end of that request.
- Drives the barrier motor up and down, monitors the up/down limit switches, holds the gate open while a car is present, then closes it automatically.
- Reports busy, open, done and fault status back to the parking logic.
- Sits between the FSM's door-open pulse and the physical gate. Runs on the 40 MHz system clock.

Parameters:
- MOVE_TIMEOUT, 80000000, max cycles allowed in OPENING or CLOSING before a fault (2 s at 40 MHz).
- HOLD_CYC, 120000000, car-free cycles the gate stays open before closing (3 s).
- CNT_W, 28, width of the internal timer; must hold max(MOVE_TIMEOUT, HOLD_CYC).

Ports:
- clk  in  1  system clock (40 MHz)
- reset_n  in  1  asynchronous, active-low reset
- open_req  in  1  single-cycle open request from the parking FSM
- car_present  in  1  debounced level: vehicle under the barrier
- lim_up  in  1  level: barrier fully up
- lim_down  in  1  level: barrier fully down
- motor_up  out  1  drive barrier upward
- motor_down  out  1  drive barrier downward
- gate_open  out  1  high while in OPEN_HOLD
- busy  out  1  high in any state other than CLOSED
- done  out  1  one-cycle pulse when a close completes at lim_down
- fault  out  1  sticky fault indicator

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Reset: state becomes CLOSED, timer 0, and every output is 0.
- Output timing: all outputs are Moore, decoded from registered state. done is a registered pulse. Any input change affects outputs exactly one cycle after it is sampled.
- Interlock: motor_up and motor_down are never 1 in the same cycle.
- States: CLOSED, OPENING, OPEN_HOLD, CLOSING, FAULT.
- CLOSED:
  - open_req=1 -> OPENING, timer cleared.
  - lim_down=0 with no open_req -> CLOSING (self-homing after reset or drift); open_req has priority.
- OPENING (motor_up=1):
  - lim_up=1 -> OPEN_HOLD, timer cleared.
  - Otherwise, timer == MOVE_TIMEOUT-1 -> FAULT.
  - open_req is ignored in this state.
- OPEN_HOLD (gate_open=1, motors off):
  - Timer increments while car_present=0.
  - car_present=1 or open_req=1 clears the timer.
  - Timer == HOLD_CYC-1 with car_present=0 -> CLOSING, timer cleared.
  - lim_up dropping while in OPEN_HOLD does not change state.
- CLOSING (motor_down=1):
  - car_present=1 or open_req=1 -> OPENING (safety reversal, timer cleared). Reversal has priority over lim_down in the same cycle.
  - Otherwise, lim_down=1 -> CLOSED and done=1 for one cycle.
  - Otherwise, timer == MOVE_TIMEOUT-1 -> FAULT.
- FAULT: motors off, fault=1, busy=1, all requests ignored. Exit only via reset_n.
- Sensor conflict: lim_up=1 and lim_down=1 in the same cycle, in any state -> FAULT next cycle. This has highest priority.
- Timer: saturates and never wraps. It is cleared on every state change.
- Reset mid-motion: motors drop asynchronously. After release, self-homing closes the gate if lim_down=0.

Test Plan (MOVE_TIMEOUT=16, HOLD_CYC=8):
- Normal cycle:
  - Stimulus: lim_down=1; open_req pulse at cycle 0; lim_up at cycle 5; car_present low; lim_down at 3 cycles into CLOSING.
  - Required: motor_up=1 from cycle 1; gate_open=1 from cycle 6; CLOSING (motor_down=1) at cycle 14; done pulse exactly once; busy=0 after.
- Hold extension:
  - Stimulus: in OPEN_HOLD, car_present=1 for cycles 3-10, then 0.
  - Required: CLOSING entered exactly 8 cycles after car_present falls.
- Safety reversal:
  - Stimulus: car_present=1 during CLOSING, simultaneous with lim_down=1.
  - Required: next state OPENING, motor_up=1, motor_down=0, no done pulse.
- Timeout:
  - Stimulus: open_req with lim_up never asserted.
  - Required: fault=1 at cycle 17; motors 0; later open_req ignored; reset_n low clears fault.
- Conflict and homing:
  - Stimulus: lim_up=lim_down=1 in OPEN_HOLD.
  - Required: fault next cycle.
  - Stimulus: separately, release reset with lim_down=0.
  - Required: motor_down=1 one cycle later.
- Interlock:
  - Stimulus: random open_req, car_present and limit traffic for 10k cycles.
  - Required: motor_up & motor_down never both 1; done only on CLOSING->CLOSED.
